mem_responder: RTL and testbench

- Memory-side responder for the CarbonCore decoder's fetch/data interface.
- Holds the 256x16 instruction RAM and the 256x8 data RAM, serves I_addr/D_addr_R reads and performs W-strobed data writes.
- Before execution, accepts a byte-serial program load from the host link, then asserts run to the Controller.
- Sits between the Clk_gen/Controller domain and the host loader; replaces the I2C-side memory model.

---
 rtl/carbon_pkg.sv | 28 ++
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder_strobe_sync.sv | 26 ++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/carbon_pkg.sv
// Shared CarbonCore definitions: responder state encoding, memory geometry and decoder opcodes.
package carbon_pkg;

  localparam int IMEM_AW = 8;
  localparam int IMEM_DW = 16;
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;
  localparam int LD_W    = 8;
  localparam int CNT_W   = 16;

  localparam logic [7:0] OP_NOP = 8'b00000000;
  localparam logic [7:0] OP_END = 8'b00111111;

  // LEN is never entered: the length byte is consumed directly from IDLE/HALT.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_LOAD_LO = 3'd3,
    ST_RUN     = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Fetch, data and host-load bus between the CarbonCore decoder/host and the memory responder.
interface mem_responder_if;
  import carbon_pkg::*;

  logic [IMEM_AW-1:0] I_addr;
  logic [IMEM_DW-1:0] IRAM;
  logic [DMEM_AW-1:0] D_addr_R;
  logic [DMEM_DW-1:0] DRAM_R;
  logic [DMEM_AW-1:0] D_addr_W;
  logic [DMEM_DW-1:0] DRAM_W;
  logic               W;
  logic               R;
  logic               ld_valid;
  logic [LD_W-1:0]    ld_data;
  logic               ld_ready;
  logic               CMDEND;
  logic               run;
  logic [CNT_W-1:0]   wr_cnt;

  modport slave (
    input  I_addr, D_addr_R, D_addr_W, DRAM_W, W, R, ld_valid, ld_data, CMDEND,
    output IRAM, DRAM_R, ld_ready, run, wr_cnt
  );

  modport master (
    output I_addr, D_addr_R, D_addr_W, DRAM_W, W, R, ld_valid, ld_data, CMDEND,
    input  IRAM, DRAM_R, ld_ready, run, wr_cnt
  );

endinterface

// File: rtl/mem_responder_strobe_sync.sv
// Multi-flop synchroniser for an asynchronous level, with a one-cycle pulse on its synchronised rising edge.
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/mem_responder.sv
// CarbonCore memory responder: byte-serial program loader, registered fetch RAM and strobed data RAM.
// Reads return one clk after the address; W-strobed writes land within 3 clk of W rising, only while running.
module mem_responder
  import carbon_pkg::*;
#(
  parameter int IMEM_DEPTH  = 256,
  parameter int DMEM_DEPTH  = 256,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam logic RD_EVERY_CLK = 1'b1;

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [IMEM_AW-1:0] last_q, last_d;
  logic [LD_W-1:0]    hi_q, hi_d;
  logic               ld_ready_q, ld_ready_d;
  logic               run_q, run_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [IMEM_DW-1:0] iram_q;
  logic [DMEM_DW-1:0] dram_q;

  logic [IMEM_DW-1:0] imem [IMEM_DEPTH];
  logic [DMEM_DW-1:0] dmem [DMEM_DEPTH];

  logic               w_rise, r_rise, cmd_rise;
  logic               ld_fire, imem_we, imem_wr, dmem_wr, dram_rd_en;
  logic [IMEM_DW-1:0] imem_wdata;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_w   (.clk(clk), .rst(rst), .async_i(bus.W),      .rise_o(w_rise));
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_r   (.clk(clk), .rst(rst), .async_i(bus.R),      .rise_o(r_rise));
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_cmd (.clk(clk), .rst(rst), .async_i(bus.CMDEND), .rise_o(cmd_rise));

  assign ld_fire    = bus.ld_valid & ld_ready_q;
  assign imem_wr    = imem_we & ~rst;
  assign imem_wdata = {hi_q, bus.ld_data};
  assign dmem_wr    = w_rise & (state_q == ST_RUN) & ~rst;
  // The R edge refresh rides on the free-running read port.
  assign dram_rd_en = RD_EVERY_CLK | r_rise;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    hi_d    = hi_q;
    imem_we = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (ld_fire) begin
          last_d  = bus.ld_data - 8'd1;  // length 0 wraps to 255, i.e. 256 words
          addr_d  = '0;
          state_d = ST_LOAD_HI;
        end
      end
      ST_LOAD_HI: begin
        if (ld_fire) begin
          hi_d    = bus.ld_data;
          state_d = ST_LOAD_LO;
        end
      end
      ST_LOAD_LO: begin
        if (ld_fire) begin
          imem_we = 1'b1;
          addr_d  = addr_q + 8'd1;
          state_d = (addr_q == last_q) ? ST_RUN : ST_LOAD_HI;
        end
      end
      ST_RUN: begin
        if (cmd_rise) state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ld_ready_d = (state_d != ST_RUN);
  assign run_d      = (state_d == ST_RUN);
  assign wr_cnt_d   = dmem_wr ? sat_inc(wr_cnt_q) : wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      hi_q       <= '0;
      ld_ready_q <= 1'b0;
      run_q      <= 1'b0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      hi_q       <= hi_d;
      ld_ready_q <= ld_ready_d;
      run_q      <= run_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_wr) imem[addr_q] <= imem_wdata;
    if (dmem_wr) dmem[bus.D_addr_W] <= bus.DRAM_W;
  end

  // Same-cycle write to the read address returns the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      iram_q <= '0;
      dram_q <= '0;
    end else begin
      iram_q <= (imem_wr && bus.I_addr == addr_q) ? imem_wdata : imem[bus.I_addr];
      if (dram_rd_en)
        dram_q <= (dmem_wr && bus.D_addr_W == bus.D_addr_R) ? bus.DRAM_W : dmem[bus.D_addr_R];
    end
  end

  assign bus.IRAM     = iram_q;
  assign bus.DRAM_R   = dram_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.run      = run_q;
  assign bus.wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed load/write tables plus random RUN traffic against a memory model.
module tb_mem_responder;
  import carbon_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] imem_m [256];
  bit          imem_k [256];
  logic [7:0]  dmem_m [256];
  bit          dmem_k [256];
  int unsigned cnt_m;
  bit          running_m;
  logic [15:0] words [256];

  typedef struct {
    logic [7:0]  wa;
    logic [7:0]  wd;
    int          width;
    logic [7:0]  ra;
    logic [7:0]  exp_r;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vt [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    while (bus.ld_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (bus.ld_ready !== 1'b1) chk("ld_ready_timeout", 32'(bus.ld_ready), 32'd1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'($urandom);
  endtask

  // Loads words[0..n-1]; n==256 is sent as length byte 0.
  task automatic load_prog(input int n);
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8]);
      chk("run_during_load", 32'(bus.run), 32'd0);
      bus.I_addr = i[7:0];
      send_byte(words[i][7:0]);
      imem_m[i] = words[i];
      imem_k[i] = 1'b1;
      chk("iram_write_first", 32'(bus.IRAM), 32'(words[i]));
      chk("run_after_word", 32'(bus.run), 32'(i == n - 1));
    end
    running_m = 1'b1;
  endtask

  // Raises W and advances exactly to the cycle after the write lands.
  task automatic pulse_w(input logic [7:0] a, input logic [7:0] v, input int width);
    bus.D_addr_W = a;
    bus.DRAM_W   = v;
    bus.W        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == width - 1) bus.W = 1'b0;
    end
    if (running_m) begin
      dmem_m[a] = v;
      dmem_k[a] = 1'b1;
      if (cnt_m < 32'hFFFF) cnt_m++;
    end
  endtask

  task automatic finish_w(input int width);
    for (int i = 3; i < width; i++) tick();
    bus.W = 1'b0;
    repeat (3) tick();
  endtask

  task automatic fetch_chk(input logic [7:0] a);
    bus.I_addr = a;
    tick();
    if (imem_k[a]) chk("fetch", 32'(bus.IRAM), 32'(imem_m[a]));
  endtask

  task automatic read_chk(input logic [7:0] a);
    bus.D_addr_R = a;
    tick();
    if (dmem_k[a]) chk("dread", 32'(bus.DRAM_R), 32'(dmem_m[a]));
  endtask

  logic [7:0] a, v, ra;
  int         width, op;

  initial begin
    vt[0] = '{wa: 8'h10, wd: 8'hA5, width: 4, ra: 8'h10, exp_r: 8'hA5, exp_cnt: 16'd1};
    vt[1] = '{wa: 8'h11, wd: 8'h3C, width: 1, ra: 8'h11, exp_r: 8'h3C, exp_cnt: 16'd2};
    vt[2] = '{wa: 8'h10, wd: 8'h5A, width: 2, ra: 8'h10, exp_r: 8'h5A, exp_cnt: 16'd3};
    vt[3] = '{wa: 8'hFF, wd: 8'h01, width: 6, ra: 8'hFF, exp_r: 8'h01, exp_cnt: 16'd4};
    vt[4] = '{wa: 8'h00, wd: 8'h80, width: 3, ra: 8'h10, exp_r: 8'h5A, exp_cnt: 16'd5};

    for (int i = 0; i < 256; i++) begin
      imem_k[i] = 1'b0;
      dmem_k[i] = 1'b0;
    end
    cnt_m = 0;
    running_m = 1'b0;
    rst = 1'b1;
    bus.I_addr = '0; bus.D_addr_R = '0; bus.D_addr_W = '0; bus.DRAM_W = '0;
    bus.W = 1'b0; bus.R = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.CMDEND = 1'b0;

    repeat (3) tick();
    chk("rst_IRAM", 32'(bus.IRAM), 32'd0);
    chk("rst_DRAM_R", 32'(bus.DRAM_R), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_run", 32'(bus.run), 32'd0);
    chk("rst_wr_cnt", 32'(bus.wr_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ld_ready", 32'(bus.ld_ready), 32'd1);

    // W while idle is ignored
    pulse_w(8'h10, 8'h55, 2);
    finish_w(2);
    chk("idle_w_cnt", 32'(bus.wr_cnt), 32'd0);

    words[0] = 16'h0007;
    words[1] = {OP_END, OP_NOP};
    load_prog(2);
    bus.I_addr = 8'd1;
    tick();
    chk("fetch_end", 32'(bus.IRAM), 32'h3F00);
    fetch_chk(8'd0);
    chk("run_ld_ready", 32'(bus.ld_ready), 32'd0);

    foreach (vt[i]) begin
      bus.D_addr_R = vt[i].ra;
      pulse_w(vt[i].wa, vt[i].wd, vt[i].width);
      chk("vec_dram_r", 32'(bus.DRAM_R), 32'(vt[i].exp_r));
      chk("vec_wr_cnt", 32'(bus.wr_cnt), 32'(vt[i].exp_cnt));
      finish_w(vt[i].width);
      chk("vec_single_write", 32'(bus.wr_cnt), 32'(vt[i].exp_cnt));
    end

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = 8'($urandom_range(0, 31));
        v = 8'($urandom);
        width = $urandom_range(1, 6);
        ra = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 31));
        bus.D_addr_R = ra;
        pulse_w(a, v, width);
        if (dmem_k[ra]) chk("rnd_dram_r", 32'(bus.DRAM_R), 32'(dmem_m[ra]));
        chk("rnd_wr_cnt", 32'(bus.wr_cnt), cnt_m);
        finish_w(width);
      end else if (op == 1) begin
        read_chk(8'($urandom_range(0, 31)));
      end else begin
        fetch_chk(8'($urandom_range(0, 1)));
      end
    end

    // CMDEND and W rise together: write still lands, then halt
    bus.D_addr_R = 8'h20;
    bus.CMDEND = 1'b1;
    pulse_w(8'h20, 8'hC3, 2);
    running_m = 1'b0;
    chk("cmd_w_run", 32'(bus.run), 32'd0);
    chk("cmd_w_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("cmd_w_dram_r", 32'(bus.DRAM_R), 32'hC3);
    chk("cmd_w_cnt", 32'(bus.wr_cnt), cnt_m);
    finish_w(2);

    bus.D_addr_R = 8'h10;
    pulse_w(8'h10, 8'h55, 3);
    chk("halt_w_dram_r", 32'(bus.DRAM_R), 32'(dmem_m[8'h10]));
    chk("halt_w_cnt", 32'(bus.wr_cnt), cnt_m);
    finish_w(3);
    bus.CMDEND = 1'b0;
    repeat (3) tick();

    words[0] = 16'($urandom);
    load_prog(1);
    fetch_chk(8'd1);

    bus.CMDEND = 1'b1;
    repeat (3) tick();
    chk("cmdend_run", 32'(bus.run), 32'd0);
    chk("cmdend_ld_ready", 32'(bus.ld_ready), 32'd1);
    bus.CMDEND = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
    load_prog(256);
    fetch_chk(8'd255);
    fetch_chk(8'd0);
    chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);

    pulse_w(8'h40, 8'h77, 1);
    finish_w(1);
    chk("pre_rst_cnt", 32'(bus.wr_cnt), cnt_m);
    rst = 1'b1;
    tick();
    chk("rst_run_drop", 32'(bus.run), 32'd0);
    chk("rst_cnt_clear", 32'(bus.wr_cnt), 32'd0);
    rst = 1'b0;
    cnt_m = 0;
    running_m = 1'b0;
    tick();
    chk("post_rst_ld_ready", 32'(bus.ld_ready), 32'd1);

    // Reset in LOAD_LO: word 0 already written must survive
    words[0] = 16'hBEEF;
    send_byte(8'd3);
    send_byte(8'hBE);
    send_byte(8'hEF);
    imem_m[0] = 16'hBEEF;
    send_byte(8'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midload_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("midload_run", 32'(bus.run), 32'd0);
    fetch_chk(8'd0);
    read_chk(8'h10);
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    load_prog(3);
    fetch_chk(8'd2);
    fetch_chk(8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
